// File: rtl/vga_pixel_capture.sv
// Capture side of the VGA path: takes a vsync-framed RGB565 stream, quantises
// each pixel to RGB332 and pushes it into the SDRAM write FIFO, one byte per pixel.
module vga_pixel_capture #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic [15:0] pix_in,
    input  logic        wfifo_full,
    output logic        wfifo_wr_en,
    output logic [7:0]  wfifo_din,
    output logic        frame_start,
    output logic        frame_done,
    output logic        overflow,
    output logic        short_frame,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [11:0] X_LAST = 12'(H_DISP - 1);
    localparam logic [11:0] Y_LAST = 12'(V_DISP - 1);

    state_t state;
    logic   vs_d;
    logic   done_pend;
    logic   vs_rise;

    // FIFO handshake: wfifo_wr_en is a one-cycle valid strobe carrying
    // wfifo_din; wfifo_full is the inverse of ready and is sampled on the same
    // cycle the pixel is offered, so a full FIFO means the pixel is lost.
    assign vs_rise   = vs_in & ~vs_d;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            vs_d        <= 1'b0;
            done_pend   <= 1'b0;
            wfifo_wr_en <= 1'b0;
            wfifo_din   <= 8'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            pix_x       <= 12'd0;
            pix_y       <= 12'd0;
        end else begin
            vs_d        <= vs_in;
            wfifo_wr_en <= 1'b0;
            frame_start <= 1'b0;
            // frame_done trails the last write strobe by one cycle
            frame_done  <= done_pend;
            done_pend   <= 1'b0;

            case (state)
                IDLE: begin
                    if (capture_en) state <= WAIT_VS;
                end

                WAIT_VS: begin
                    if (vs_rise) begin
                        state       <= CAPTURE;
                        pix_x       <= 12'd0;
                        pix_y       <= 12'd0;
                        frame_start <= 1'b1;
                        overflow    <= 1'b0;
                        short_frame <= 1'b0;
                    end else if (!capture_en) begin
                        state <= IDLE;
                    end
                end

                CAPTURE: begin
                    if (vs_rise) begin
                        // early vsync: frame is truncated, restart without clearing flags
                        short_frame <= 1'b1;
                        pix_x       <= 12'd0;
                        pix_y       <= 12'd0;
                        if (capture_en) frame_start <= 1'b1;
                        else            state       <= IDLE;
                    end else if (de_in && wfifo_full) begin
                        overflow <= 1'b1;
                        state    <= DROP;
                    end else if (de_in) begin
                        wfifo_wr_en <= 1'b1;
                        wfifo_din   <= {pix_in[15:13], pix_in[10:8], pix_in[4:3]};
                        if (pix_x == X_LAST) begin
                            pix_x <= 12'd0;
                            if (pix_y == Y_LAST) begin
                                pix_y     <= 12'd0;
                                done_pend <= 1'b1;
                                state     <= capture_en ? WAIT_VS : IDLE;
                            end else begin
                                pix_y <= pix_y + 12'd1;
                            end
                        end else begin
                            pix_x <= pix_x + 12'd1;
                        end
                    end
                end

                DROP: begin
                    if (vs_rise) begin
                        pix_x <= 12'd0;
                        pix_y <= 12'd0;
                        if (capture_en) begin
                            state       <= CAPTURE;
                            frame_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pixel_capture.sv
// Bench for vga_pixel_capture on a reduced 8x4 frame: a linear pixel-count
// reference model predicts every registered output each cycle.
module tb_vga_pixel_capture;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_en = 1'b0;
    logic        vs_in = 1'b0;
    logic        de_in = 1'b0;
    logic [15:0] pix_in = 16'd0;
    logic        wfifo_full = 1'b0;
    logic        wfifo_wr_en;
    logic [7:0]  wfifo_din;
    logic        frame_start;
    logic        frame_done;
    logic        overflow;
    logic        short_frame;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [1:0]  state_dbg;

    vga_pixel_capture #(.H_DISP(H), .V_DISP(V)) dut (
        .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .vs_in(vs_in),
        .de_in(de_in), .pix_in(pix_in), .wfifo_full(wfifo_full),
        .wfifo_wr_en(wfifo_wr_en), .wfifo_din(wfifo_din),
        .frame_start(frame_start), .frame_done(frame_done),
        .overflow(overflow), .short_frame(short_frame),
        .pix_x(pix_x), .pix_y(pix_y), .state_dbg(state_dbg)
    );

    // clock / reset
    always #20 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    // reference model: mode 0 off, 1 armed, 2 taking pixels, 3 discarding
    int         m_mode = 0;
    int         m_count = 0;
    logic       m_vs_prev = 1'b0;
    logic       m_done_pend = 1'b0;
    logic       e_wr = 1'b0, e_start = 1'b0, e_done = 1'b0;
    logic       e_ovf = 1'b0, e_short = 1'b0;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] quant(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return 8'((r / 4) * 32 + (g / 8) * 4 + (b / 8));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic rise;
        rise    = vs_in && !m_vs_prev;
        e_wr    = 1'b0;
        e_start = 1'b0;
        e_done  = m_done_pend;
        m_done_pend = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_count = 0; m_vs_prev = 1'b0;
            e_done = 1'b0; e_ovf = 1'b0; e_short = 1'b0;
            return;
        end
        m_vs_prev = vs_in;
        case (m_mode)
            0: if (capture_en) m_mode = 1;
            1: begin
                if (rise) begin
                    m_mode = 2; m_count = 0; e_start = 1'b1; e_ovf = 1'b0; e_short = 1'b0;
                end else if (!capture_en) m_mode = 0;
            end
            2: begin
                if (rise) begin
                    e_short = 1'b1; m_count = 0;
                    if (capture_en) e_start = 1'b1; else m_mode = 0;
                end else if (de_in && wfifo_full) begin
                    e_ovf = 1'b1; m_mode = 3;
                end else if (de_in) begin
                    e_wr = 1'b1;
                    exp_q.push_back(quant(pix_in));
                    m_count++;
                    if (m_count == H * V) begin
                        m_count = 0; m_done_pend = 1'b1;
                        m_mode = capture_en ? 1 : 0;
                    end
                end
            end
            default: begin
                if (rise) begin
                    m_count = 0;
                    if (capture_en) begin m_mode = 2; e_start = 1'b1; end
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        logic [7:0] exp_b;
        if (wfifo_wr_en) wr_count++;
        chk("wr_en", wfifo_wr_en, e_wr);
        if (e_wr) begin
            exp_b = exp_q.pop_front();
            if (wfifo_wr_en) chk("din", wfifo_din, exp_b);
        end
        chk("frame_start", frame_start, e_start);
        chk("frame_done", frame_done, e_done);
        chk("overflow", overflow, e_ovf);
        chk("short_frame", short_frame, e_short);
        chk("pix_x", pix_x, 12'(m_count % H));
        chk("pix_y", pix_y, 12'(m_count / H));
    endtask

    // driver: apply inputs, advance one clock, compare on the falling edge
    task automatic drive(input logic r, input logic en, input logic vs, input logic de,
                         input logic full, input logic [15:0] p);
        rst_n = r; capture_en = en; vs_in = vs; de_in = de; wfifo_full = full; pix_in = p;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic vs_pulse();
        drive(1, 1, 1, 0, 0, 16'd0);
        drive(1, 1, 1, 0, 0, 16'd0);
        drive(1, 1, 0, 0, 0, 16'd0);
    endtask

    initial begin
        int vs_timer;
        int vs_hold;
        logic en_r;

        // reset
        drive(0, 0, 0, 0, 0, 16'd0);
        drive(0, 1, 1, 1, 0, 16'hFFFF);
        chk("reset_state", state_dbg, 2'd0);

        // full frame of white pixels
        drive(1, 1, 0, 0, 0, 16'd0);
        drive(1, 1, 0, 0, 0, 16'd0);
        vs_pulse();
        wr_count = 0;
        for (int i = 0; i < H * V; i++) drive(1, 1, 0, 1, 0, 16'hFFFF);
        drive(1, 1, 0, 0, 0, 16'd0);
        drive(1, 1, 0, 0, 0, 16'd0);
        chk("frame_writes", wr_count, H * V);

        // quantisation example, then a frame with de gaps every other cycle
        vs_pulse();
        wr_count = 0;
        drive(1, 1, 0, 1, 0, 16'b10110_101100_01101);
        chk("quant_example", wfifo_din, 8'b101_101_01);
        for (int i = 0; i < 2 * (H * V - 1); i++)
            drive(1, 1, 0, (i % 2) == 1, 0, 16'($urandom));
        drive(1, 1, 0, 0, 0, 16'd0);
        drive(1, 1, 0, 0, 0, 16'd0);
        chk("gap_frame_writes", wr_count, H * V);

        // FIFO full mid-frame at (5,1): drop until next vsync
        vs_pulse();
        for (int i = 0; i < H + 5; i++) drive(1, 1, 0, 1, 0, 16'($urandom));
        drive(1, 1, 0, 1, 1, 16'($urandom));
        wr_count = 0;
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 1, 0, 16'($urandom));
        chk("drop_no_writes", wr_count, 0);
        vs_pulse();
        for (int i = 0; i < 6; i++) drive(1, 1, 0, 1, 0, 16'($urandom));
        chk("overflow_sticky", overflow, 1'b1);

        // early vsync truncates the frame
        vs_pulse();
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 1, 0, 16'($urandom));
        drive(1, 1, 1, 1, 0, 16'($urandom));
        chk("short_set", short_frame, 1'b1);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 1, 0, 16'($urandom));

        // reset mid-frame: nothing written until a fresh vsync
        drive(0, 1, 0, 1, 0, 16'($urandom));
        chk("midreset_state", state_dbg, 2'd0);
        wr_count = 0;
        for (int i = 0; i < 6; i++) drive(1, 1, 0, 1, 0, 16'($urandom));
        chk("post_reset_no_writes", wr_count, 0);

        // randomized traffic
        vs_timer = 40;
        vs_hold = 0;
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic vs_v;
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            vs_v = 1'b0;
            if (vs_hold > 0) begin
                vs_v = 1'b1; vs_hold--;
            end else if (vs_timer == 0) begin
                vs_v = 1'b1; vs_hold = $urandom_range(0, 2);
                vs_timer = $urandom_range(25, 60);
            end else begin
                vs_timer--;
            end
            drive($urandom_range(0, 499) != 0, en_r, vs_v, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
